// File: rtl/regfile_write_arbiter.sv
// Two-port round-robin write arbiter for an 8 x 16-bit load-select register bank.
// Optional macro REGFILE_ZERO_REG_EN: register 0 reads as zero, so writes to it raise no load select.
module regfile_write_arbiter #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            freeze,
    input  logic            req0_valid,
    input  logic [2:0]      req0_addr,
    input  logic [DW-1:0]   req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [2:0]      req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic            req1_ready,
    output logic [NREG-1:0] wr_sel,
    output logic [DW-1:0]   wr_data,
    output logic            last_grant
);

    logic [NREG-1:0] wr_sel_q,     wr_sel_d;
    logic [DW-1:0]   wr_data_q,    wr_data_d;
    logic            last_grant_q, last_grant_d;
    logic            gnt0_s, gnt1_s;
    logic [2:0]      acc_addr_s;
    logic [DW-1:0]   acc_data_s;

    function automatic logic [NREG-1:0] addr_onehot(input logic [2:0] addr);
        logic [NREG-1:0] sel;
        sel = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            sel[i] = (addr == i[2:0]);
        end
        return sel;
    endfunction

    // Grant: a lone requester wins outright; under contention the port that did not win last time wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset && !freeze) begin
            gnt0_s = req0_valid && (!req1_valid || last_grant_q);
            gnt1_s = req1_valid && (!req0_valid || !last_grant_q);
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Mux the accepted request onto the shared address/data path.
    always_comb begin
        acc_addr_s = 3'd0;
        acc_data_s = {DW{1'b0}};
        if (gnt1_s) begin
            acc_addr_s = req1_addr;
            acc_data_s = req1_data;
        end else begin
            acc_addr_s = req0_addr;
            acc_data_s = req0_data;
        end
    end

    // Next state: one-hot select for one cycle after an accept; data bus holds between writes.
    always_comb begin
        wr_sel_d     = {NREG{1'b0}};
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        if (gnt0_s || gnt1_s) begin
            last_grant_d = gnt1_s;
`ifdef REGFILE_ZERO_REG_EN
            if (acc_addr_s != 3'd0) begin
                wr_sel_d  = addr_onehot(acc_addr_s);
                wr_data_d = acc_data_s;
            end else begin
                wr_sel_d  = {NREG{1'b0}};
                wr_data_d = wr_data_q;
            end
`else
            wr_sel_d  = addr_onehot(acc_addr_s);
            wr_data_d = acc_data_s;
`endif
        end else begin
            wr_sel_d     = {NREG{1'b0}};
            wr_data_d    = wr_data_q;
            last_grant_d = last_grant_q;
        end
    end

    // State registers; last_grant resets to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel_q     <= {NREG{1'b0}};
            wr_data_q    <= {DW{1'b0}};
            last_grant_q <= 1'b1;
        end else begin
            wr_sel_q     <= wr_sel_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wr_sel     = wr_sel_q;
    assign wr_data    = wr_data_q;
    assign last_grant = last_grant_q;

endmodule
